// File: rtl/kronos_wb_sched.sv
// Write-back scheduler: shares the regfile write port between EX and LD results,
// tracks pending writes and raises decode stalls. Optional bypass: KRONOS_WB_BYPASS_EN.
module kronos_wb_sched #(
  parameter int unsigned STARVE_MAX = 32'd4
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic        flush,
  input  logic        issue_vld,
  input  logic        issue_rdy,
  input  logic        issue_regwr,
  input  logic [4:0]  issue_rd,
  input  logic        rs1_en,
  input  logic        rs2_en,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        stall,
  input  logic        ex_vld,
  output logic        ex_rdy,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_data,
  input  logic        ld_vld,
  output logic        ld_rdy,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        regwr_en,
  output logic [4:0]  regwr_sel,
  output logic [31:0] regwr_data,
  output logic        fwd1,
  output logic        fwd2,
  output logic [31:0] fwd_data,
  output logic        sb_err
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

  logic [31:0]      pending_r;
  logic [31:0]      pending_s;
  logic [CNT_W-1:0] starve_cnt_r;
  logic [CNT_W-1:0] starve_cnt_s;
  logic             sb_err_r;
  logic             sb_err_s;
  logic             regwr_en_r;
  logic [4:0]       regwr_sel_r;
  logic [31:0]      regwr_data_r;

  logic             ld_win_s;
  logic             ex_win_s;
  logic [4:0]       win_rd_s;
  logic [31:0]      win_data_s;
  logic             commit_s;

  logic             raw1_s;
  logic             raw2_s;
  logic             waw_s;
  logic             hit1_s;
  logic             hit2_s;
  logic             hitw_s;
  logic             stall_s;
  logic             fire_s;

  // Grant: LD wins ties unless EX has already lost STARVE_MAX cycles in a row.
  always_comb begin
    ld_win_s     = 1'b0;
    ex_win_s     = 1'b0;
    win_rd_s     = ex_rd;
    win_data_s   = ex_data;
    starve_cnt_s = starve_cnt_r;
    if (ld_vld && !(ex_vld && (starve_cnt_r == CNT_MAX))) begin
      ld_win_s   = 1'b1;
      win_rd_s   = ld_rd;
      win_data_s = ld_data;
    end else if (ex_vld) begin
      ex_win_s = 1'b1;
    end else begin
      ld_win_s = 1'b0;
    end
    if (!ex_vld || ex_win_s) begin
      starve_cnt_s = {CNT_W{1'b0}};
    end else if (ld_win_s && (starve_cnt_r != CNT_MAX)) begin
      starve_cnt_s = starve_cnt_r + CNT_ONE;
    end else begin
      starve_cnt_s = starve_cnt_r;
    end
  end

  assign commit_s = (ex_win_s | ld_win_s) & (win_rd_s != 5'd0);

  // Hazard detection; with bypass, a register committing this cycle is not a hazard.
  always_comb begin
    raw1_s = rs1_en & pending_r[rs1] & (rs1 != 5'd0);
    raw2_s = rs2_en & pending_r[rs2] & (rs2 != 5'd0);
    waw_s  = issue_vld & issue_regwr & (issue_rd != 5'd0) & pending_r[issue_rd];
`ifdef KRONOS_WB_BYPASS_EN
    hit1_s = regwr_en_r & (regwr_sel_r == rs1);
    hit2_s = regwr_en_r & (regwr_sel_r == rs2);
    hitw_s = regwr_en_r & (regwr_sel_r == issue_rd);
`else
    hit1_s = 1'b0;
    hit2_s = 1'b0;
    hitw_s = 1'b0;
`endif
    stall_s = (raw1_s & ~hit1_s) | (raw2_s & ~hit2_s) | (waw_s & ~hitw_s);
    fire_s  = issue_vld & issue_rdy & ~flush & ~stall_s;
  end

  // Scoreboard update: commit clears first, a same-edge issue set then wins.
  always_comb begin
    pending_s = pending_r;
    sb_err_s  = sb_err_r;
    if (regwr_en_r) begin
      if (!pending_r[regwr_sel_r]) begin
        sb_err_s = 1'b1;
      end else begin
        sb_err_s = sb_err_r;
      end
      pending_s[regwr_sel_r] = 1'b0;
    end else begin
      pending_s = pending_r;
    end
    if (fire_s && issue_regwr && (issue_rd != 5'd0)) begin
      pending_s[issue_rd] = 1'b1;
    end else begin
      sb_err_s = sb_err_s;
    end
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      pending_r    <= 32'd0;
      starve_cnt_r <= {CNT_W{1'b0}};
      sb_err_r     <= 1'b0;
      regwr_en_r   <= 1'b0;
      regwr_sel_r  <= 5'd0;
      regwr_data_r <= 32'd0;
    end else begin
      pending_r    <= pending_s;
      starve_cnt_r <= starve_cnt_s;
      sb_err_r     <= sb_err_s;
      regwr_en_r   <= commit_s;
      if (commit_s) begin
        regwr_sel_r  <= win_rd_s;
        regwr_data_r <= win_data_s;
      end
    end
  end

  assign ex_rdy     = rstz & ex_win_s;
  assign ld_rdy     = rstz & ld_win_s;
  assign stall      = rstz & stall_s;
  assign fwd1       = rstz & raw1_s & hit1_s;
  assign fwd2       = rstz & raw2_s & hit2_s;
  assign regwr_en   = regwr_en_r;
  assign regwr_sel  = regwr_sel_r;
  assign regwr_data = regwr_data_r;
  assign sb_err     = sb_err_r;
`ifdef KRONOS_WB_BYPASS_EN
  assign fwd_data   = regwr_data_r;
`else
  assign fwd_data   = 32'd0;
`endif

endmodule

// File: tb/tb_kronos_wb_sched.sv
// Randomized scoreboard bench for kronos_wb_sched with a queue/array reference model.
module tb_kronos_wb_sched;

  localparam int STARVE = 4;
`ifdef KRONOS_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstz, flush, issue_vld, issue_rdy, issue_regwr;
  logic [4:0]  issue_rd, rs1, rs2, ex_rd, ld_rd, regwr_sel;
  logic        rs1_en, rs2_en, stall, ex_vld, ex_rdy, ld_vld, ld_rdy;
  logic [31:0] ex_data, ld_data, regwr_data, fwd_data;
  logic        regwr_en, fwd1, fwd2, sb_err;

  always #5 clk = ~clk;

  kronos_wb_sched #(.STARVE_MAX(STARVE)) dut (
    .clk(clk), .rstz(rstz), .flush(flush), .issue_vld(issue_vld), .issue_rdy(issue_rdy),
    .issue_regwr(issue_regwr), .issue_rd(issue_rd), .rs1_en(rs1_en), .rs2_en(rs2_en),
    .rs1(rs1), .rs2(rs2), .stall(stall), .ex_vld(ex_vld), .ex_rdy(ex_rdy), .ex_rd(ex_rd),
    .ex_data(ex_data), .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_rd(ld_rd), .ld_data(ld_data),
    .regwr_en(regwr_en), .regwr_sel(regwr_sel), .regwr_data(regwr_data), .fwd1(fwd1),
    .fwd2(fwd2), .fwd_data(fwd_data), .sb_err(sb_err)
  );

  typedef struct packed {logic [4:0] rd; logic [31:0] data;} wr_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  int          ex_src_q[$];
  int          ld_src_q[$];
  logic [31:0] m_pend = 32'd0;
  bit          m_err = 1'b0;
  int          m_cnt = 0;
  bit          m_infl = 1'b0;
  logic [4:0]  m_infl_rd = 5'd0;
  logic [31:0] m_infl_data = 32'd0;
  bit          ex_taken = 1'b0;
  bit          ld_taken = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every regfile write must match the oldest expected commit.
  always @(posedge clk) begin
    #1;
    if (rstz && regwr_en) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL regwr_unexpected: got write x%0d, expected none at %0t", regwr_sel, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("regwr_sel", {27'd0, regwr_sel}, {27'd0, mon_e.rd});
        check("regwr_data", regwr_data, mon_e.data);
      end
    end
  end

  // One cycle from a negedge: apply stimulus, check combinational outputs, advance model.
  task automatic drive_cycle(input bit allow_issue);
    bit e_ld, e_ex, r1, r2, w, b1, b2, bw, e_stall, fire;
    if (ex_taken) ex_vld = 1'b0;
    if (ld_taken) ld_vld = 1'b0;
    ex_taken = 1'b0;
    ld_taken = 1'b0;
    if (!ex_vld) begin
      if (ex_src_q.size() != 0 && $urandom_range(0, 99) < 60) begin
        ex_vld = 1'b1; ex_rd = 5'(ex_src_q.pop_front()); ex_data = $urandom;
      end else if (allow_issue && $urandom_range(0, 99) < 5) begin
        ex_vld = 1'b1; ex_rd = 5'd0; ex_data = $urandom;
      end
    end
    if (!ld_vld) begin
      if (ld_src_q.size() != 0 && $urandom_range(0, 99) < 60) begin
        ld_vld = 1'b1; ld_rd = 5'(ld_src_q.pop_front()); ld_data = $urandom;
      end else if (allow_issue && $urandom_range(0, 99) < 8) begin
        ld_vld = 1'b1; ld_rd = 5'd0; ld_data = $urandom;
      end
    end
    issue_vld   = allow_issue && ($urandom_range(0, 99) < 70);
    issue_rdy   = ($urandom_range(0, 99) < 80);
    flush       = allow_issue && ($urandom_range(0, 99) < 10);
    issue_regwr = ($urandom_range(0, 99) < 75);
    issue_rd    = 5'($urandom_range(0, 7));
    rs1_en      = ($urandom_range(0, 99) < 60);
    rs2_en      = ($urandom_range(0, 99) < 60);
    rs1         = 5'($urandom_range(0, 7));
    rs2         = 5'($urandom_range(0, 7));
    #1;
    e_ld = ld_vld && !(ex_vld && m_cnt == STARVE);
    e_ex = ex_vld && !e_ld;
    r1 = rs1_en && rs1 != 5'd0 && m_pend[rs1];
    r2 = rs2_en && rs2 != 5'd0 && m_pend[rs2];
    w  = issue_vld && issue_regwr && issue_rd != 5'd0 && m_pend[issue_rd];
    b1 = BYP && m_infl && m_infl_rd == rs1;
    b2 = BYP && m_infl && m_infl_rd == rs2;
    bw = BYP && m_infl && m_infl_rd == issue_rd;
    e_stall = (r1 && !b1) || (r2 && !b2) || (w && !bw);
    check("ld_rdy", {31'd0, ld_rdy}, {31'd0, e_ld});
    check("ex_rdy", {31'd0, ex_rdy}, {31'd0, e_ex});
    check("stall", {31'd0, stall}, {31'd0, e_stall});
    check("fwd1", {31'd0, fwd1}, {31'd0, r1 && b1});
    check("fwd2", {31'd0, fwd2}, {31'd0, r2 && b2});
    check("sb_err", {31'd0, sb_err}, {31'd0, m_err});
    if (!BYP) check("fwd_data_off", fwd_data, 32'd0);
    else if (m_infl) check("fwd_data", fwd_data, m_infl_data);
    fire = issue_vld && issue_rdy && !flush && !e_stall;
    if (m_infl) begin
      if (!m_pend[m_infl_rd]) m_err = 1'b1;
      m_pend[m_infl_rd] = 1'b0;
    end
    if (fire && issue_regwr && issue_rd != 5'd0) begin
      m_pend[issue_rd] = 1'b1;
      if ($urandom_range(0, 1) == 0) ex_src_q.push_back(int'(issue_rd));
      else ld_src_q.push_back(int'(issue_rd));
    end
    if (!ex_vld || e_ex) m_cnt = 0;
    else if (e_ld && m_cnt < STARVE) m_cnt++;
    m_infl = 1'b0;
    if (e_ld && ld_rd != 5'd0) begin
      m_infl = 1'b1; m_infl_rd = ld_rd; m_infl_data = ld_data;
    end else if (e_ex && ex_rd != 5'd0) begin
      m_infl = 1'b1; m_infl_rd = ex_rd; m_infl_data = ex_data;
    end
    if (m_infl) exp_q.push_back('{rd: m_infl_rd, data: m_infl_data});
    ex_taken = e_ex;
    ld_taken = e_ld;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((ex_src_q.size() != 0 || ld_src_q.size() != 0 || ex_vld || ld_vld) && n < 400) begin
      drive_cycle(1'b0);
      n++;
    end
    if (n >= 400) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d cycles, expected < 400", n);
    end
    repeat (2) drive_cycle(1'b0);
  endtask

  logic [9:0] grant_pat = 10'b0111101111;

  initial begin
    rstz = 1'b0; flush = 1'b0; issue_vld = 1'b0; issue_rdy = 1'b0; issue_regwr = 1'b0;
    issue_rd = 5'd0; rs1_en = 1'b1; rs2_en = 1'b1; rs1 = 5'd3; rs2 = 5'd4;
    ex_vld = 1'b0; ex_rd = 5'd0; ex_data = 32'd0; ld_vld = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
    repeat (2) @(negedge clk);
    ex_vld = 1'b1; ld_vld = 1'b1; ld_rd = 5'd3;
    #1;
    check("rst_ex_rdy", {31'd0, ex_rdy}, 32'd0);
    check("rst_ld_rdy", {31'd0, ld_rdy}, 32'd0);
    check("rst_regwr_en", {31'd0, regwr_en}, 32'd0);
    check("rst_regwr_sel", {27'd0, regwr_sel}, 32'd0);
    check("rst_regwr_data", regwr_data, 32'd0);
    check("rst_sb_err", {31'd0, sb_err}, 32'd0);
    ex_vld = 1'b0; ld_vld = 1'b0; ld_rd = 5'd0; rs1_en = 1'b0; rs2_en = 1'b0;
    @(negedge clk);
    rstz = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_regwr_en", {31'd0, regwr_en}, 32'd0);
    check("post_rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);

    // EX and LD both held: expected grant order LD x4 then EX, twice.
    ex_vld = 1'b1; ld_vld = 1'b1; ex_rd = 5'd0; ld_rd = 5'd0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("starve_ld_rdy", {31'd0, ld_rdy}, {31'd0, grant_pat[i]});
      check("starve_ex_rdy", {31'd0, ex_rdy}, {31'd0, ~grant_pat[i]});
      check("x0_no_write", {31'd0, regwr_en}, 32'd0);
      @(negedge clk);
    end
    ex_vld = 1'b0; ld_vld = 1'b0;

    repeat (1500) drive_cycle(1'b1);
    drain();
    check("no_err_random", {31'd0, sb_err}, 32'd0);

    // Commit to a register that was never issued.
    ex_src_q.push_back(9);
    drain();
    check("sb_err_set", {31'd0, sb_err}, 32'd1);
    repeat (3) drive_cycle(1'b0);
    check("sb_err_sticky", {31'd0, sb_err}, 32'd1);

    // Reset while a commit is in flight, with another register still pending.
    issue_vld = 1'b1; issue_rdy = 1'b1; flush = 1'b0; issue_regwr = 1'b1; issue_rd = 5'd5;
    rs1_en = 1'b0; rs2_en = 1'b0;
    #1 check("dir_issue5_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    issue_rd = 5'd4;
    #1 check("dir_issue4_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    issue_vld = 1'b0; rs1_en = 1'b1; rs1 = 5'd5;
    ld_vld = 1'b1; ld_rd = 5'd4; ld_data = 32'hA5A5_1234;
    exp_q.push_back('{rd: 5'd4, data: 32'hA5A5_1234});
    #1;
    check("dir_raw_stall", {31'd0, stall}, 32'd1);
    check("dir_ld_rdy", {31'd0, ld_rdy}, 32'd1);
    @(negedge clk);
    ld_vld = 1'b0;
    #1 check("dir_inflight", {31'd0, regwr_en}, 32'd1);
    rstz = 1'b0;
    #1;
    check("midrst_regwr_en", {31'd0, regwr_en}, 32'd0);
    check("midrst_regwr_sel", {27'd0, regwr_sel}, 32'd0);
    check("midrst_regwr_data", regwr_data, 32'd0);
    check("midrst_sb_err", {31'd0, sb_err}, 32'd0);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rstz = 1'b1; rs2_en = 1'b1; rs2 = 5'd4;
    #1;
    check("midrst_pending_cleared", {31'd0, stall}, 32'd0);
    check("midrst_sb_err_after", {31'd0, sb_err}, 32'd0);
    @(negedge clk);
    #1 check("midrst_no_commit", {31'd0, regwr_en}, 32'd0);
    check("exp_q_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
